// File: rtl/msu_coef_normalize.sv
// Carry-propagating normaliser: turns redundant BIT_LEN-bit coefficients into a plain
// WORD_LEN-per-word integer, one coefficient per clock, least significant word first.
module msu_coef_normalize #(
    parameter int unsigned MOD_LEN            = 1024,
    parameter int unsigned WORD_LEN           = 16,
    parameter int unsigned BIT_LEN            = 17,
    parameter int unsigned REDUNDANT_ELEMENTS = 2,
    parameter int unsigned NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
    parameter int unsigned COEF_BITS          = NUM_ELEMENTS * WORD_LEN * 2,
    parameter int unsigned RES_BITS           = NUM_ELEMENTS * WORD_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [COEF_BITS-1:0] coef_in,
    output logic                 busy,
    output logic                 valid,
    output logic [RES_BITS-1:0]  result,
    output logic                 overflow
);

    localparam int unsigned SlotW = 32;
    localparam int unsigned CntW  = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [BIT_LEN-1:0]  coef_q [NUM_ELEMENTS];
    logic [WORD_LEN-1:0] word_q [NUM_ELEMENTS];
    logic [CntW-1:0]     cnt_q;
    logic [1:0]          carry_q;
    logic                overflow_q;

    logic                accept;
    logic                last_elem;
    logic [BIT_LEN:0]    acc;
    logic [1:0]          carry_nxt;
    logic                unused_coef_bits;

    // Slot bits above BIT_LEN carry no value and are deliberately dropped.
    assign unused_coef_bits = ^coef_in;

    assign accept    = (state_q == StIdle) && start;
    assign last_elem = (cnt_q == CntW'(NUM_ELEMENTS - 1));
    assign acc       = {1'b0, coef_q[cnt_q]} + {{(BIT_LEN - 1){1'b0}}, carry_q};
    assign carry_nxt = 2'(acc >> WORD_LEN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_elem) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        valid = 1'b0;
        unique case (state_q)
            StIdle:  busy = 1'b0;
            StRun:   busy = 1'b1;
            StDone: begin
                busy  = 1'b1;
                valid = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Coefficient snapshot; contents are don't-care until the next accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < int'(NUM_ELEMENTS); i++) begin
                coef_q[i] <= coef_in[SlotW*i +: BIT_LEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            carry_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(NUM_ELEMENTS); i++) begin
                word_q[i] <= '0;
            end
        end else if (accept) begin
            cnt_q   <= '0;
            carry_q <= '0;
        end else if (state_q == StRun) begin
            word_q[cnt_q] <= acc[WORD_LEN-1:0];
            carry_q       <= carry_nxt;
            cnt_q         <= cnt_q + CntW'(1);
            if (last_elem) begin
                overflow_q <= (carry_nxt != 2'd0);
            end
        end
    end

    always_comb begin
        result = '0;
        for (int j = 0; j < int'(NUM_ELEMENTS); j++) begin
            result[WORD_LEN*j +: WORD_LEN] = word_q[j];
        end
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_msu_coef_normalize.sv
// Directed bench for msu_coef_normalize: hand-computed carry chains, latency, start
// filtering while busy, and mid-run reset.
module tb_msu_coef_normalize;

    localparam int NE        = 66;
    localparam int WL        = 16;
    localparam int COEF_BITS = NE * WL * 2;
    localparam int RES_BITS  = NE * WL;

    logic                 clk_ext = 1'b0;
    logic                 reset;
    logic                 start;
    logic [COEF_BITS-1:0] coef_in;
    logic                 busy;
    logic                 valid;
    logic [RES_BITS-1:0]  result;
    logic                 overflow;

    int checks = 0;
    int errors = 0;

    logic [WL-1:0] exp_w [NE];

    msu_coef_normalize dut (
        .clk      (clk_ext),
        .reset    (reset),
        .start    (start),
        .coef_in  (coef_in),
        .busy     (busy),
        .valid    (valid),
        .result   (result),
        .overflow (overflow)
    );

    always #5 clk_ext = ~clk_ext;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ext);
        #1;
    endtask

    task automatic check_words(input string tag);
        for (int j = 0; j < NE; j++) begin
            check($sformatf("%s_word%0d", tag, j), 64'(result[j*WL +: WL]), 64'(exp_w[j]));
        end
    endtask

    task automatic clear_exp();
        for (int j = 0; j < NE; j++) exp_w[j] = '0;
    endtask

    // Drives start for one cycle; returns in cycle 1 of the conversion.
    task automatic launch(input logic [COEF_BITS-1:0] c);
        coef_in = c;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Advances from cycle c0 until valid is seen or the budget expires.
    task automatic wait_valid(input int c0, output int cyc);
        cyc = c0;
        while (!valid && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic finish_run(input string tag, input int c0, input logic exp_ovf);
        int cyc;
        wait_valid(c0, cyc);
        check({tag, "_latency"}, 64'(cyc), 64'd67);
        check({tag, "_busy_at_valid"}, 64'(busy), 64'd1);
        check_words(tag);
        check({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
        tick();
        check({tag, "_valid_drop"}, 64'(valid), 64'd0);
        check({tag, "_busy_drop"}, 64'(busy), 64'd0);
    endtask

    logic [COEF_BITS-1:0] v031, v032, v033, v034, vzero;
    int                   cyc;
    int                   stray;

    initial begin
        vzero = '0;
        v031  = '0;
        v031[31:0]  = 32'h0001_0000;
        v032  = '0;
        v032[31:0]  = 32'h0001_FFFF;
        v032[63:32] = 32'h0000_FFFF;
        for (int j = 0; j < NE; j++) v033[32*j +: 32] = 32'h0001_FFFF;
        for (int j = 0; j < NE; j++) v034[32*j +: 32] = 32'hFFFE_0000;
        v034[31:0] = 32'hFFFE_0003;

        reset   = 1'b1;
        start   = 1'b0;
        coef_in = '0;
        tick();
        tick();
        reset = 1'b0;

        clear_exp();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check_words("rst");

        // Single carry out of word 0.
        launch(v031);
        check("t031_busy_run", 64'(busy), 64'd1);
        clear_exp();
        exp_w[1] = 16'h0001;
        finish_run("t031", 1, 1'b0);

        // Worst case: carry saturates at 2 and stays there.
        launch(v033);
        for (int j = 0; j < NE; j++) exp_w[j] = 16'h0001;
        exp_w[0] = 16'hFFFF;
        exp_w[1] = 16'h0000;
        finish_run("t033", 1, 1'b1);

        // Unwritten words and overflow hold the previous result mid-run.
        launch(v032);
        for (int k = 0; k < 4; k++) tick();
        check("t032_mid_word0", 64'(result[15:0]), 64'hFFFF);
        check("t032_mid_word40", 64'(result[40*WL +: WL]), 64'h0001);
        check("t032_mid_overflow", 64'(overflow), 64'd1);
        clear_exp();
        exp_w[0] = 16'hFFFF;
        exp_w[2] = 16'h0001;
        finish_run("t032", 5, 1'b0);

        // Upper slot bits are ignored.
        launch(v034);
        clear_exp();
        exp_w[0] = 16'h0003;
        finish_run("t034", 1, 1'b0);

        // Start while busy is ignored; start in the DONE cycle is ignored too.
        launch(v032);
        for (int k = 0; k < 9; k++) tick();
        coef_in = v031;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        coef_in = v032;
        wait_valid(11, cyc);
        check("t035_latency", 64'(cyc), 64'd67);
        clear_exp();
        exp_w[0] = 16'hFFFF;
        exp_w[2] = 16'h0001;
        check_words("t035");
        coef_in = v031;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("t035_done_start_ignored", 64'(busy), 64'd0);
        check("t035_single_valid", 64'(valid), 64'd0);

        // First IDLE cycle accepts a new start.
        launch(v031);
        clear_exp();
        exp_w[1] = 16'h0001;
        finish_run("t025", 1, 1'b0);

        // Reset mid-run (with a start in the reset cycle), then restart at cycle 35.
        launch(v033);
        for (int k = 0; k < 29; k++) tick();
        reset   = 1'b1;
        start   = 1'b1;
        coef_in = v031;
        tick();
        reset   = 1'b0;
        start   = 1'b0;
        check("t036_busy_after_rst", 64'(busy), 64'd0);
        check("t036_valid_after_rst", 64'(valid), 64'd0);
        check("t036_overflow_after_rst", 64'(overflow), 64'd0);
        check("t036_word0_after_rst", 64'(result[15:0]), 64'h0000);
        check("t036_word1_after_rst", 64'(result[31:16]), 64'h0000);
        stray = 0;
        for (int k = 31; k < 35; k++) begin
            if (valid || busy || result != '0) stray++;
            tick();
        end
        launch(vzero);
        cyc = 1;
        while (!valid && cyc < 200) begin
            if (result != '0) stray++;
            tick();
            cyc++;
        end
        check("t036_no_stray_activity", 64'(stray), 64'd0);
        check("t036_latency", 64'(cyc), 64'd67);
        clear_exp();
        check_words("t036");
        check("t036_overflow", 64'(overflow), 64'd0);
        tick();
        check("t036_valid_drop", 64'(valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
